serial_uart_tx: RTL and testbench

Byte-wide UART transmitter that sits at the serial end of the IO controller's outbound path. It accepts bytes through the write/full FIFO handshake (the IO controller's `SerialData_out` / `SerialWrite` / `SerialFull` side) and buffers them in an internal FIFO. Each byte is then serialized as an 8N1 frame (optionally 8E1) on the board's TX pin. The block targets the DE0-Nano 50 MHz clock.

---
 rtl/serial_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_serial_uart_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_uart_tx.sv
// Byte-wide UART transmitter with an internal FIFO; 8N1 frames on tx.
// Define SERIAL_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module serial_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic       full,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } stateT;

    logic [7:0]        mem [DEPTH];
    logic [FIFO_AW:0]  wrPtr, rdPtr, count, countNext;
    logic              push, pop, fifoEmpty;
    logic [7:0]        head;
    logic              unusedPtrMsb;

    stateT             state, stateNext;
    logic [BAUD_W-1:0] baudCnt, baudNext;
    logic [2:0]        bitIdx, bitNext;
    logic [7:0]        shiftReg, shiftNext;
    logic              txNext;
    logic              bitEnd;

    assign push         = write && !full;
    assign fifoEmpty    = (count == '0);
    assign head         = mem[rdPtr[FIFO_AW-1:0]];
    assign bitEnd       = (baudCnt == BAUD_LAST);
    assign busy         = (state != IDLE) || !fifoEmpty;
    // Pointers run free; only the low FIFO_AW bits address the buffer.
    assign unusedPtrMsb = wrPtr[FIFO_AW] ^ rdPtr[FIFO_AW];

    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem[wrPtr[FIFO_AW-1:0]] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            count <= countNext;
            full  <= (countNext == CNT_FULL);
        end
    end

`ifdef SERIAL_UART_TX_PARITY_EN
    // Parity is latched at pop time because the shift register is consumed.
    logic parityBit;
    always_ff @(posedge clock) begin
        if (!reset_n)  parityBit <= 1'b0;
        else if (pop)  parityBit <= ^head;
    end
`endif

    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        txNext    = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baudNext = '0;
                txNext   = 1'b1;
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    shiftNext = head;
                    bitNext   = '0;
                    stateNext = START;
                    txNext    = 1'b0;
                end
            end
            START: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    stateNext = DATA;
                    txNext    = shiftReg[0];
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    shiftNext = shiftReg >> 1;
                    if (bitIdx == 3'd7) begin
`ifdef SERIAL_UART_TX_PARITY_EN
                        stateNext = PARITY;
                        txNext    = parityBit;
`else
                        stateNext = STOP;
                        txNext    = 1'b1;
`endif
                    end else begin
                        bitNext = bitIdx + 1'b1;
                        txNext  = shiftReg[1];
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
`ifdef SERIAL_UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    stateNext = STOP;
                    txNext    = 1'b1;
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    baudNext = '0;
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        shiftNext = head;
                        bitNext   = '0;
                        stateNext = START;
                        txNext    = 1'b0;
                    end else begin
                        stateNext = IDLE;
                        txNext    = 1'b1;
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                baudNext  = '0;
                txNext    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            tx       <= txNext;
        end
    end

endmodule

// File: tb/tb_serial_uart_tx.sv
// Directed bench for serial_uart_tx with CLKS_PER_BIT=4, depth 8.
// Honours SERIAL_UART_TX_PARITY_EN for frame length and the parity bit.
module tb_serial_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef SERIAL_UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] dataIn;
    logic       write;
    logic       full, tx, busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    serial_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (3)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .data_in(dataIn),
        .write  (write),
        .full   (full),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Caller sits at a negedge whose following posedge is the frame's start edge.
    task automatic expectFrame(input logic [7:0] b, input string tag);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef SERIAL_UART_TX_PARITY_EN
        bits[9]   = ^b;
`endif
        for (int unsigned j = 0; j < FRAME_BITS; j++) begin
            for (int unsigned c = 0; c < CPB; c++) begin
                @(negedge clock);
                checkVal($sformatf("%s bit%0d", tag, j), tx, bits[j]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        write   = 1'b0;
        dataIn  = '0;

        repeat (3) begin
            @(negedge clock);
            checkVal("rst tx", tx, 1);
            checkVal("rst full", full, 0);
            checkVal("rst busy", busy, 0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checkVal("post-rst tx", tx, 1);
        checkVal("post-rst busy", busy, 0);

        // Single byte into an idle block
        write  = 1'b1;
        dataIn = 8'hA5;
        @(negedge clock);
        write  = 1'b0;
        dataIn = 8'hFF;
        checkVal("a5 tx before pop", tx, 1);
        checkVal("a5 busy queued", busy, 1);
        expectFrame(8'hA5, "a5");
        @(negedge clock);
        checkVal("a5 busy end", busy, 0);
        checkVal("a5 tx idle", tx, 1);

        // Nine consecutive writes plus one dropped while full
        write  = 1'b1;
        dataIn = 8'h00;
        fork
            begin
                for (int unsigned i = 0; i < 10; i++) begin
                    dataIn = (i == 9) ? 8'h99 : 8'(i);
                    @(negedge clock);
                    checkVal($sformatf("burst full w%0d", i), full, (i >= 8) ? 1 : 0);
                end
                write = 1'b0;
                repeat (FRAME_CYC - 9) @(negedge clock);
                checkVal("burst full before pop", full, 1);
                @(negedge clock);
                checkVal("burst full after pop", full, 0);
            end
            begin
                @(negedge clock);
                for (int unsigned k = 0; k < 9; k++)
                    expectFrame(8'(k), $sformatf("burst f%0d", k));
            end
        join
        @(negedge clock);
        checkVal("burst busy end", busy, 0);
        checkVal("burst tx idle", tx, 1);

        // Hold write with 0xFF while full: one accepted per freed slot
        write  = 1'b1;
        dataIn = 8'h10;
        fork
            begin
                for (int unsigned i = 0; i < 9; i++) begin
                    dataIn = 8'h10 + 8'(i);
                    @(negedge clock);
                end
                checkVal("hold full", full, 1);
                dataIn = 8'hFF;
                repeat (FRAME_CYC - 8) @(negedge clock);
                checkVal("hold full pre-pop", full, 1);
                @(negedge clock);
                checkVal("hold full pop1", full, 0);
                @(negedge clock);
                checkVal("hold full refill1", full, 1);
                repeat (FRAME_CYC) @(negedge clock);
                checkVal("hold full refill2", full, 1);
                write  = 1'b0;
                dataIn = 8'h00;
            end
            begin
                @(negedge clock);
                for (int unsigned k = 0; k < 9; k++)
                    expectFrame(8'h10 + 8'(k), $sformatf("hold f%0d", k));
                expectFrame(8'hFF, "hold ff0");
                expectFrame(8'hFF, "hold ff1");
            end
        join
        @(negedge clock);
        checkVal("hold busy end", busy, 0);
        checkVal("hold tx idle", tx, 1);

        // Reset during data bit 3 of a 0x3C frame with 0x55 queued behind it
        write  = 1'b1;
        dataIn = 8'h3C;
        @(negedge clock);
        dataIn = 8'h55;
        @(negedge clock);
        write  = 1'b0;
        checkVal("abort start bit", tx, 0);
        repeat (16) @(negedge clock);
        checkVal("abort bit3", tx, 1);
        checkVal("abort busy pre", busy, 1);
        reset_n = 1'b0;
        @(negedge clock);
        checkVal("abort tx", tx, 1);
        checkVal("abort busy", busy, 0);
        checkVal("abort full", full, 0);
        reset_n = 1'b1;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clock);
            checkVal($sformatf("abort quiet c%0d", i), {busy, tx}, 2'b01);
        end

`ifdef SERIAL_UART_TX_PARITY_EN
        // 0x07 has odd weight -> parity 1; 0x03 even weight -> parity 0
        write  = 1'b1;
        dataIn = 8'h07;
        @(negedge clock);
        write  = 1'b0;
        expectFrame(8'h07, "par07");
        @(negedge clock);
        checkVal("par07 busy end", busy, 0);
        write  = 1'b1;
        dataIn = 8'h03;
        @(negedge clock);
        write  = 1'b0;
        expectFrame(8'h03, "par03");
        @(negedge clock);
        checkVal("par03 busy end", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
